pipe_delay_reg: RTL and testbench



---
 rtl/pipe_delay_reg.sv | 58 +++++
 tb/tb_pipe_delay_reg.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_delay_reg.sv
// WIDTH-bit, STAGES-deep retiming pipeline with per-stage valid, stall, clear/set
// and a registered count of stages currently holding valid data.
module pipe_delay_reg #(
    parameter int                 WIDTH     = 4,
    parameter int                 STAGES    = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter logic [WIDTH-1:0]   SET_VAL   = {WIDTH{1'b1}},
    localparam int                CW        = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sclr,
    input  logic             sset,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    output logic [CW-1:0]    count,
    output logic             busy
);

    logic [WIDTH-1:0] s [STAGES];
    logic [STAGES-1:0] v;
    logic [CW:0]       count_nxt;

    // One extra bit so the add/subtract cannot wrap; the result is always 0..STAGES.
    assign count_nxt = {1'b0, count} + (CW + 1)'(in_valid) - (CW + 1)'(v[STAGES-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) s[i] <= RESET_VAL;
            v     <= '0;
            count <= '0;
        end else if (sclr) begin
            for (int i = 0; i < STAGES; i++) s[i] <= RESET_VAL;
            v     <= '0;
            count <= '0;
        end else if (sset) begin
            for (int i = 0; i < STAGES; i++) s[i] <= SET_VAL;
            v     <= '0;
            count <= '0;
        end else if (en) begin
            s[0] <= d;
            v[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
                v[i] <= v[i-1];
            end
            count <= count_nxt[CW-1:0];
        end
    end

    assign q         = s[STAGES-1];
    assign out_valid = v[STAGES-1];
    assign busy      = (count != '0);

endmodule

// File: tb/tb_pipe_delay_reg.sv
// Directed bench for pipe_delay_reg at WIDTH=8, STAGES=3; expected values hand-computed.
module tb_pipe_delay_reg;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       sclr;
    logic       sset;
    logic [7:0] d;
    logic       in_valid;
    logic [7:0] q;
    logic       out_valid;
    logic [1:0] count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    pipe_delay_reg #(
        .WIDTH(8), .STAGES(3), .RESET_VAL(8'h00), .SET_VAL(8'hFF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sclr(sclr), .sset(sset),
        .d(d), .in_valid(in_valid), .q(q), .out_valid(out_valid),
        .count(count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            assert (!$isunknown({en, sclr, sset})) else begin
                errors++;
                $error("FAIL ctrl_x observed=%b expected=no X", {en, sclr, sset});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eq, input logic eov,
                           input logic [1:0] ecnt);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, ".count"}, 32'(count), 32'(ecnt));
        chk({tag, ".busy"}, 32'(busy), 32'(ecnt != 2'd0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic iv, input logic [7:0] dv);
        en = e; in_valid = iv; d = dv;
    endtask

    initial begin
        reset_n = 1'b1; en = 1'b0; sclr = 1'b0; sset = 1'b0; d = 8'h00; in_valid = 1'b0;

        // Asynchronous reset before any clock edge
        #2 reset_n = 1'b0;
        #1 chk_out("rst_async", 8'h00, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 8'hEE);
        step(); chk_out("rst_hold1", 8'h00, 1'b0, 2'd0);
        step(); chk_out("rst_hold2", 8'h00, 1'b0, 2'd0);
        reset_n = 1'b1;

        // Latency and full-pipeline count
        drive(1'b1, 1'b1, 8'h11); step(); chk_out("lat1", 8'h00, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 8'h22); step(); chk_out("lat2", 8'h00, 1'b0, 2'd2);
        drive(1'b1, 1'b1, 8'h33); step(); chk_out("lat3", 8'h11, 1'b1, 2'd3);
        drive(1'b1, 1'b1, 8'hA1); step(); chk_out("lat4", 8'h22, 1'b1, 2'd3);
        drive(1'b1, 1'b1, 8'hA2); step(); chk_out("lat5", 8'h33, 1'b1, 2'd3);
        drive(1'b1, 1'b1, 8'hA3); step(); chk_out("lat6", 8'hA1, 1'b1, 2'd3);

        // Stall: pipeline holds A1/A2/A3 (q=A1)
        drive(1'b0, 1'b0, 8'hEE);
        for (int i = 0; i < 4; i++) begin
            step(); chk_out("stall", 8'hA1, 1'b1, 2'd3);
        end
        drive(1'b1, 1'b0, 8'h00);
        step(); chk_out("resume1", 8'hA2, 1'b1, 2'd2);
        step(); chk_out("resume2", 8'hA3, 1'b1, 2'd1);
        step(); chk_out("drain", 8'h00, 1'b0, 2'd0);
        step(); chk_out("empty_stay", 8'h00, 1'b0, 2'd0);

        // Bubbles
        drive(1'b1, 1'b1, 8'h01); step(); chk_out("bub1", 8'h00, 1'b0, 2'd1);
        drive(1'b1, 1'b0, 8'h02); step(); chk_out("bub2", 8'h00, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 8'h03); step(); chk_out("bub3", 8'h01, 1'b1, 2'd2);
        drive(1'b1, 1'b0, 8'h00); step(); chk_out("bub4", 8'h02, 1'b0, 2'd1);
        step(); chk_out("bub5", 8'h03, 1'b1, 2'd1);
        step(); chk_out("bub6", 8'h00, 1'b0, 2'd0);

        // Set / clear priority
        drive(1'b1, 1'b1, 8'hB1); step();
        drive(1'b1, 1'b1, 8'hB2); step();
        drive(1'b1, 1'b1, 8'hB3); step(); chk_out("fill", 8'hB1, 1'b1, 2'd3);
        sset = 1'b1; step(); chk_out("sset", 8'hFF, 1'b0, 2'd0);
        sclr = 1'b1; step(); chk_out("sclr_sset", 8'h00, 1'b0, 2'd0);
        sset = 1'b0; drive(1'b1, 1'b1, 8'h77);
        step(); chk_out("sclr_en", 8'h00, 1'b0, 2'd0);
        sclr = 1'b0; drive(1'b1, 1'b0, 8'h00);
        step(); chk_out("post_sclr1", 8'h00, 1'b0, 2'd0);
        step(); chk_out("post_sclr2", 8'h00, 1'b0, 2'd0);
        step(); chk_out("post_sclr3", 8'h00, 1'b0, 2'd0);

        // Reset mid-stream
        drive(1'b1, 1'b1, 8'hC1); step();
        drive(1'b1, 1'b1, 8'hC2); step(); chk_out("pre_rst", 8'h00, 1'b0, 2'd2);
        drive(1'b1, 1'b0, 8'h00);
        #3 reset_n = 1'b0;
        #1 chk_out("rst_mid", 8'h00, 1'b0, 2'd0);
        step(); chk_out("rst_mid_hold", 8'h00, 1'b0, 2'd0);
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 8'h5A); step(); chk_out("rel1", 8'h00, 1'b0, 2'd1);
        drive(1'b1, 1'b0, 8'h00); step(); chk_out("rel2", 8'h00, 1'b0, 2'd1);
        step(); chk_out("rel3", 8'h5A, 1'b1, 2'd1);
        step(); chk_out("rel4", 8'h00, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
